xor_descrambler_16bit: RTL and testbench
========================================

// Module: xor_descrambler_16bit
// PURPOSE
//  Receive-side additive descrambler. XORs each accepted 16-bit word with a keystream word
//  from a 16-bit Fibonacci LFSR, undoing the matching scrambler on the transmit side.
//  Input and output both use valid/ready. A 2-entry output FIFO decouples the two sides.
//  Sits between the link receive port and the processor's memory-mapped input register.
// PARAMETERS
//  RESET_SEED  16'hACE1  LFSR value loaded at reset. Not used until the first seed_load.
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  seed_load   in   1   one-cycle pulse: load seed_in, flush FIFO, enter RUN
//  seed_in     in   16  LFSR seed, sampled when seed_load=1
//  in_valid    in   1   in_data holds a scrambled word
//  in_data     in   16  scrambled word
//  in_ready    out  1   descrambler accepts the word this cycle
//  out_valid   out  1   out_data holds a descrambled word (FIFO not empty)
//  out_data    out  16  descrambled word at the FIFO head
//  out_ready   in   1   downstream takes the word this cycle
//  word_count  out  16  words accepted since the last seed_load
// BEHAVIOUR
//  Reset (async assert, sync to clk on release):
//   - state=IDLE, lfsr=RESET_SEED, FIFO empty, word_count=0
//   - in_ready=0, out_valid=0, out_data=0
//  States:
//   - IDLE: in_ready=0. seed_load -> RUN.
//   - RUN: normal operation. seed_load -> RUN (re-seed). There is no other exit.
//  seed_load (either state, highest priority):
//   - lfsr <= (seed_in==0) ? 16'h0001 : seed_in. The zero guard prevents LFSR lock-up.
//   - FIFO emptied and word_count cleared on the same edge.
//   - Any pop or push in that cycle is discarded.
//  in_ready = (state==RUN) && (fifo_count!=2) && !seed_load. Purely combinational.
//  Accept = in_valid && in_ready. On accept:
//   - push in_data ^ lfsr.
//   - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. One shift per word.
//   - word_count += 1, wrapping 16'hFFFF -> 16'h0000.
//  The LFSR never advances without an accept; in_valid stalls leave it frozen.
//  Latency: a word accepted at edge N is visible on out_data after edge N when the FIFO was empty.
//  Output:
//   - out_valid = fifo_count!=0
//   - out_data = FIFO head; it holds stable while out_valid && !out_ready.
//   - Pop on out_valid && out_ready.
//  Simultaneous push and pop:
//   - count 1: count stays 1, head advances to the new word.
//   - count 2: in_ready=0, so only the pop occurs.
//  FIFO is strictly in order. No overflow or underflow is possible by construction.
//  Mid-operation reset: all state returns to reset values immediately. The upstream must
//  re-seed before traffic resumes.
// TESTING
//  1. Reset, no seed_load, in_valid=1 for 10 cycles -> in_ready=0, out_valid=0, word_count=0.
//  2. seed_load seed 16'hACE1, then word 16'h0000 -> out 16'hACE1.
//     Next word 16'hFFFF -> out 16'hA63C (lfsr 16'h59C3). word_count=2.
//  3. seed_load seed 16'h0000, word 16'h1234 -> out 16'h1235 (zero-seed guard, lfsr=1).
//  4. out_ready=0, 3 words offered -> 2 accepted, in_ready=0 on the third.
//     Then out_ready=1 -> words drain in order, and the third is accepted at fifo_count=1.
//  5. FIFO holding 2 words, pulse seed_load with in_valid=1 -> out_valid=0 next cycle,
//     input not accepted, word_count=0.
//  6. 65536 accepts -> word_count wraps to 0.
//     Back-to-back random words against a bit-accurate scrambler model -> data round-trips exactly.

Source files
------------

// File: rtl/xor_descrambler_16bit.sv
// Receive-side additive descrambler: 16-bit Fibonacci LFSR keystream,
// valid/ready on both sides, 2-entry output FIFO.
module xor_descrambler_16bit #(
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [15:0] word_count
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic [15:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;
  logic        accept;
  logic        pop;

  assign in_ready  = (state == RUN) && (cnt != 2'd2) && !seed_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
  // seed_load flushes the FIFO, so a same-cycle pop is dropped
  assign pop       = out_valid && out_ready && !seed_load;
  assign lfsr_nx   = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      seed_load: state_nx = RUN;
      default:   state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= RESET_SEED;
      mem[0]     <= 16'h0000;
      mem[1]     <= 16'h0000;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      word_count <= 16'h0000;
    end else if (seed_load) begin
      // an all-zero LFSR would lock up
      lfsr       <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      word_count <= 16'h0000;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_data ^ lfsr;
        wr_ptr      <= ~wr_ptr;
        lfsr        <= lfsr_nx;
        word_count  <= word_count + 16'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_descrambler_16bit.sv
// Directed bench for xor_descrambler_16bit.
// Hand-computed vectors plus a scrambler model for the long run.
module tb_xor_descrambler_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [15:0] word_count;

  int vectors = 0;
  int miscompares = 0;

  xor_descrambler_16bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ks_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    #3;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 16'h0 || word_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b data=%h wc=%h want 0 0 0000 0000",
               in_ready, out_valid, out_data, word_count);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || word_count !== 16'h0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: rdy=%b vld=%b wc=%h want 0 0 0000",
                 i, in_ready, out_valid, word_count);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_seed_basic();
    do_seed(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0000;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL run_ready: got %b want 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'hACE1 || word_count !== 16'd1) begin
      miscompares++;
      $display("FAIL first_word: vld=%b data=%h wc=%h want 1 ace1 0001",
               out_valid, out_data, word_count);
    end
    out_ready = 1'b1; in_data = 16'hFFFF;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'hA63C || word_count !== 16'd2) begin
      miscompares++;
      $display("FAIL second_word: vld=%b data=%h wc=%h want 1 a63c 0002",
               out_valid, out_data, word_count);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || word_count !== 16'd2) begin
      miscompares++;
      $display("FAIL drain_basic: vld=%b wc=%h want 0 0002", out_valid, word_count);
    end
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (word_count !== 16'd2 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold: vld=%b wc=%h want 0 0002", out_valid, word_count);
    end
  endtask

  task automatic test_zero_seed();
    do_seed(16'h0000);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h1235 || word_count !== 16'd1) begin
      miscompares++;
      $display("FAIL zero_seed: vld=%b data=%h wc=%h want 1 1235 0001",
               out_valid, out_data, word_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_seed(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready1: got %b want 1", in_ready);
    end
    tick();
    in_data = 16'h3333;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready: got %b want 0", in_ready);
    end
    tick();
    vectors++;
    if (word_count !== 16'd2 || out_data !== 16'hBDF0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: vld=%b data=%h wc=%h want 1 bdf0 0002",
               out_valid, out_data, word_count);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_pop_only: rdy=%b want 0", in_ready);
    end
    tick();
    vectors++;
    if (out_data !== 16'h7BE1 || word_count !== 16'd2 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain1: data=%h wc=%h rdy=%b want 7be1 0002 1",
               out_data, word_count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 16'h80B4 || word_count !== 16'd3 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_third: vld=%b data=%h wc=%h want 1 80b4 0003",
               out_valid, out_data, word_count);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: vld=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_seed(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA;
    tick();
    tick();
    seed_load = 1'b1; seed_in = 16'h0F0F; in_data = 16'hBBBB;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || word_count !== 16'd0) begin
      miscompares++;
      $display("FAIL flush: vld=%b wc=%h want 0 0000", out_valid, word_count);
    end
    in_valid = 1'b1; in_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 16'h0F0F || word_count !== 16'd1) begin
      miscompares++;
      $display("FAIL reseed_word: data=%h wc=%h want 0f0f 0001", out_data, word_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ks;
    logic [15:0] d;
    logic [15:0] exp;
    int          errs;
    errs = 0;
    ks = 16'hBEEF;
    do_seed(ks);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      d = 16'($urandom);
      in_data = d ^ 16'h0;
      exp = d ^ ks;
      tick();
      ks = ks_next(ks);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        miscompares++;
        if (errs < 5)
          $display("FAIL roundtrip%0d: vld=%b data=%h want 1 %h",
                   i, out_valid, out_data, exp);
        errs++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (word_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL wc_wrap: got %h want 0000", word_count);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_seed(16'h1234);
    in_valid = 1'b1; in_data = 16'h0; out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || word_count !== 16'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: vld=%b wc=%h rdy=%b want 0 0000 0",
               out_valid, word_count, in_ready);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_seed_basic();
    test_zero_seed();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
